// File: rtl/clock_gen_pkg.sv
// rtl/clock_gen_pkg.sv - shared constants and types for the clock generator bank
package clock_gen_pkg;

  localparam int CNT_W_DEFAULT = 27;
  localparam int MAX_CH        = 16;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  typedef enum logic {
    BLK_ON,
    BLK_OFF
  } blink_t;

endpackage

// File: rtl/clock_div_ch.sv
// rtl/clock_div_ch.sv - one divider channel: counter, active/shadow divisor, square wave and tick
module clock_div_ch
  import clock_gen_pkg::*;
#(
  parameter int              CNT_W    = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DIV_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_div,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act;
  logic [CNT_W-1:0] shd;
  logic [CNT_W-1:0] shd_next;

  assign shd_next = ld ? ld_div : shd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      act     <= DIV_INIT;
      shd     <= DIV_INIT;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (sync) begin
      cnt     <= '0;
      act     <= shd_next;
      shd     <= shd_next;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      shd <= shd_next;
      if (act == '0) begin
        // halted: a pending divisor takes over at once, counting starts from zero
        cnt     <= '0;
        act     <= shd_next;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (cnt == act - 1'b1) begin
        cnt     <= '0;
        act     <= shd_next;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_gen_bank.sv
// rtl/clock_gen_bank.sv - multi-channel programmable clock/tick generator
// Optional blink output enabled by defining CLKGEN_BLINK_EN.
module clock_gen_bank
  import clock_gen_pkg::*;
#(
  parameter int                    NUM_CH   = 4,
  parameter int                    CNT_W    = CNT_W_DEFAULT,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {NUM_CH{27'd50_000_000}}
`ifdef CLKGEN_BLINK_EN
  ,
  parameter logic [7:0]            BLINK_CH  = 8'd1,
  parameter logic [7:0]            BLINK_ON  = 8'd3,
  parameter logic [7:0]            BLINK_OFF = 8'd1
`endif
) (
  input  logic              CLK_REF,
  input  logic              CLK_RES,
  input  logic              SYNC,
  input  logic              LD_EN,
  input  logic [3:0]        LD_CH,
  input  logic [CNT_W-1:0]  LD_DIV,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK
`ifdef CLKGEN_BLINK_EN
  ,
  output logic              CLK_BLINK
`endif
);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("clock_gen_bank: NUM_CH out of range");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_div_ch #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk     (CLK_REF),
      .rst     (CLK_RES),
      .sync    (SYNC),
      .ld      (LD_EN && (LD_CH == 4'(i))),
      .ld_div  (LD_DIV),
      .clk_out (CLK_OUT[i]),
      .tick    (TICK[i])
    );
  end

`ifdef CLKGEN_BLINK_EN
  blink_t     blk_state;
  logic [7:0] blk_cnt;

  // blink phase counts ticks of the selected channel, not reference cycles
  always_ff @(posedge CLK_REF or posedge CLK_RES) begin
    if (CLK_RES) begin
      blk_state <= BLK_ON;
      blk_cnt   <= '0;
      CLK_BLINK <= (BLINK_ON != 8'd0);
    end else if (SYNC) begin
      blk_state <= BLK_ON;
      blk_cnt   <= '0;
      CLK_BLINK <= (BLINK_ON != 8'd0);
    end else if (BLINK_ON == 8'd0) begin
      CLK_BLINK <= 1'b0;
    end else if (BLINK_OFF == 8'd0) begin
      CLK_BLINK <= 1'b1;
    end else if (TICK[BLINK_CH]) begin
      unique case (blk_state)
        BLK_ON: begin
          if (blk_cnt == BLINK_ON - 8'd1) begin
            blk_state <= BLK_OFF;
            blk_cnt   <= '0;
            CLK_BLINK <= 1'b0;
          end else begin
            blk_cnt <= blk_cnt + 8'd1;
          end
        end
        BLK_OFF: begin
          if (blk_cnt == BLINK_OFF - 8'd1) begin
            blk_state <= BLK_ON;
            blk_cnt   <= '0;
            CLK_BLINK <= 1'b1;
          end else begin
            blk_cnt <= blk_cnt + 8'd1;
          end
        end
        default: begin
          blk_state <= BLK_ON;
          blk_cnt   <= '0;
        end
      endcase
    end
  end
`endif

endmodule
